// File: rtl/m_stage_mem_if.sv
`default_nettype none
// ============================================================================
//  Module      : m_stage_mem_if
//  Description : Data-memory request/acknowledge bus used by the M stage.
//                master = M stage (drives request side),
//                slave  = memory (drives ack/rdata).
//  Signals     : mem_req   1   bus request
//                mem_we    1   1 = store
//                mem_addr  32  word-aligned address
//                mem_be    4   byte enables
//                mem_wdata 32  lane-replicated store data
//                mem_ack   1   access complete this cycle
//                mem_rdata 32  read word (valid with mem_ack on loads)
//  Revision    : 1.0  initial release
// ============================================================================
interface m_stage_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_be,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_be,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/m_stage_mem.sv
`default_nettype none
// ============================================================================
//  Module      : m_stage_mem
//  Description : MIPS memory-access stage plus M/W pipeline register.
//                Decodes load/store from IRM, runs a req/ack data-memory
//                access with byte enables and replicated store data, stalls
//                the pipe until the access completes (or times out), then
//                registers IRW/PC4W/AOW/DRW/ExcW into Writeback.
//                DRW holds the raw aligned word; extraction is done in W.
//  Ports       : clk, reset          clock, synchronous active-high reset
//                IRM/PC4M/AOM/RTM    M-stage instruction, PC+4, ALU result,
//                                    forwarded store data
//                mem                 data-memory bus (master modport)
//                stall_m             freeze PC/F/D/E/M this cycle
//                IRW/PC4W/AOW/DRW    Writeback pipeline registers
//                ExcW                00 none, 01 load misaligned,
//                                    10 store misaligned, 11 bus timeout
//  Revision    : 1.0  initial release
// ============================================================================
module m_stage_mem #(
    parameter int TIMEOUT = 255
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic [31:0] IRM,
    input  wire logic [31:0] PC4M,
    input  wire logic [31:0] AOM,
    input  wire logic [31:0] RTM,
    m_stage_mem_if.master    mem,
    output logic             stall_m,
    output logic [31:0]      IRW,
    output logic [31:0]      PC4W,
    output logic [31:0]      AOW,
    output logic [31:0]      DRW,
    output logic [1:0]       ExcW
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] C_TMO = CW'(TIMEOUT);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    localparam logic [1:0] C_EXC_NONE = 2'b00;
    localparam logic [1:0] C_EXC_LDMA = 2'b01;
    localparam logic [1:0] C_EXC_STMA = 2'b10;
    localparam logic [1:0] C_EXC_TMO  = 2'b11;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [5:0] w_op;
    logic       w_lw, w_lb, w_lbu, w_lh, w_lhu, w_sw, w_sb, w_sh;
    logic       w_is_load, w_is_store, w_is_word, w_is_half;
    logic       w_misaligned, w_aligned_op;

    assign w_op  = IRM[31:26];
    assign w_lw  = (w_op == 6'b100011);
    assign w_lb  = (w_op == 6'b100000);
    assign w_lbu = (w_op == 6'b100100);
    assign w_lh  = (w_op == 6'b100001);
    assign w_lhu = (w_op == 6'b100101);
    assign w_sw  = (w_op == 6'b101011);
    assign w_sb  = (w_op == 6'b101000);
    assign w_sh  = (w_op == 6'b101001);

    assign w_is_load    = w_lw | w_lb | w_lbu | w_lh | w_lhu;
    assign w_is_store   = w_sw | w_sb | w_sh;
    assign w_is_word    = w_lw | w_sw;
    assign w_is_half    = w_lh | w_lhu | w_sh;
    assign w_misaligned = (w_is_word & (AOM[1:0] != 2'b00)) | (w_is_half & AOM[0]);
    assign w_aligned_op = (w_is_load | w_is_store) & ~w_misaligned;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   irw_q, irw_d, pc4w_q, pc4w_d, aow_q, aow_d, drw_q, drw_d;
    logic [1:0]    excw_q, excw_d;

    logic w_req;
    logic w_tmo_hit;

    // The last WAIT cycle without ack retires the instruction with a bus
    // error; the pipe must advance on that cycle so the access is not
    // re-issued, hence stall_m is released even though mem_req is still up.
    assign w_tmo_hit = (state_q == S_WAIT) & (cnt_q == C_TMO) & ~mem.mem_ack;

    // Reset also gates the request so a dropped access never reappears
    // while the pipeline is being cleared.
    assign w_req   = ~reset & (((state_q == S_IDLE) & w_aligned_op) | (state_q == S_WAIT));
    assign stall_m = w_req & ~mem.mem_ack & ~w_tmo_hit;

    // ------------------------------------------------------------------
    // Bus drive: combinational from M inputs, which the hazard unit holds
    // while stall_m is asserted.
    // ------------------------------------------------------------------
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = 32'h0;
        if (w_sb) begin
            w_be    = 4'b0001 << AOM[1:0];
            w_wdata = {4{RTM[7:0]}};
        end else if (w_sh) begin
            w_be    = AOM[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{RTM[15:0]}};
        end else if (w_sw) begin
            w_be    = 4'b1111;
            w_wdata = RTM;
        end else if (w_is_load) begin
            w_be    = 4'b1111;
        end
    end

    assign mem.mem_req   = w_req;
    assign mem.mem_we    = w_is_store;
    assign mem.mem_addr  = {AOM[31:2], 2'b00};
    assign mem.mem_be    = w_be;
    assign mem.mem_wdata = w_wdata;

    // ------------------------------------------------------------------
    // Next-state / Writeback register logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        // default: bubble into W
        irw_d   = 32'h0;
        pc4w_d  = 32'h0;
        aow_d   = 32'h0;
        drw_d   = 32'h0;
        excw_d  = C_EXC_NONE;

        case (state_q)
            S_IDLE: begin
                if (w_aligned_op & ~mem.mem_ack) begin
                    state_d = S_WAIT;
                    cnt_d   = CW'(1);
                end else begin
                    // non-memory, misaligned, or zero-wait access
                    irw_d  = IRM;
                    pc4w_d = PC4M;
                    aow_d  = AOM;
                    if (w_aligned_op & w_is_load) begin
                        drw_d = mem.mem_rdata;
                    end
                    if (w_misaligned) begin
                        excw_d = w_is_load ? C_EXC_LDMA : C_EXC_STMA;
                    end
                end
            end
            S_WAIT: begin
                if (mem.mem_ack) begin
                    irw_d   = IRM;
                    pc4w_d  = PC4M;
                    aow_d   = AOM;
                    drw_d   = w_is_load ? mem.mem_rdata : 32'h0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == C_TMO) begin
                    irw_d   = IRM;
                    pc4w_d  = PC4M;
                    aow_d   = AOM;
                    excw_d  = C_EXC_TMO;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            irw_q   <= 32'h0;
            pc4w_q  <= 32'h0;
            aow_q   <= 32'h0;
            drw_q   <= 32'h0;
            excw_q  <= C_EXC_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            irw_q   <= irw_d;
            pc4w_q  <= pc4w_d;
            aow_q   <= aow_d;
            drw_q   <= drw_d;
            excw_q  <= excw_d;
        end
    end

    assign IRW  = irw_q;
    assign PC4W = pc4w_q;
    assign AOW  = aow_q;
    assign DRW  = drw_q;
    assign ExcW = excw_q;

endmodule
`default_nettype wire

// File: tb/tb_m_stage_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_m_stage_mem
//  Description : Directed self-checking bench for m_stage_mem (TIMEOUT = 4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_m_stage_mem;

    logic        clk;
    logic        reset;
    logic [31:0] IRM, PC4M, AOM, RTM;
    logic        stall_m;
    logic [31:0] IRW, PC4W, AOW, DRW;
    logic [1:0]  ExcW;

    int tests = 0;
    int fails = 0;

    m_stage_mem_if bus();

    m_stage_mem #(.TIMEOUT(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .IRM     (IRM),
        .PC4M    (PC4M),
        .AOM     (AOM),
        .RTM     (RTM),
        .mem     (bus),
        .stall_m (stall_m),
        .IRW     (IRW),
        .PC4W    (PC4W),
        .AOW     (AOW),
        .DRW     (DRW),
        .ExcW    (ExcW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] C_ADDU = 32'h0022_1821;
    localparam logic [31:0] C_LW   = 32'h8C41_0000;
    localparam logic [31:0] C_SB   = 32'hA041_0003;
    localparam logic [31:0] C_SH   = 32'hA541_0002;
    localparam logic [31:0] C_LH   = 32'h8441_0001;
    localparam logic [31:0] C_SW   = 32'hAC41_0002;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance one clock; sample point is 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        IRM = 32'h0; PC4M = 32'h0; AOM = 32'h0; RTM = 32'h0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
        tick(); tick();
        chk("rst_req",   {31'h0, bus.mem_req}, 32'h0);
        chk("rst_stall", {31'h0, stall_m}, 32'h0);
        chk("rst_IRW",   IRW, 32'h0);
        chk("rst_PC4W",  PC4W, 32'h0);
        chk("rst_DRW",   DRW, 32'h0);
        chk("rst_ExcW",  {30'h0, ExcW}, 32'h0);
        reset = 1'b0;

        // ---- non-memory instruction: latency 1, never stalls
        IRM = C_ADDU; PC4M = 32'h104; AOM = 32'd5;
        #1;
        chk("addu_stall", {31'h0, stall_m}, 32'h0);
        chk("addu_req",   {31'h0, bus.mem_req}, 32'h0);
        tick();
        chk("addu_IRW",  IRW, C_ADDU);
        chk("addu_AOW",  AOW, 32'd5);
        chk("addu_PC4W", PC4W, 32'h104);
        chk("addu_ExcW", {30'h0, ExcW}, 32'h0);

        // ---- lw acked on the 4th cycle: 3 stall cycles, 3 bubbles
        IRM = C_LW; PC4M = 32'h108; AOM = 32'h100;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lw_stall", {31'h0, stall_m}, 32'h1);
            chk("lw_req",   {31'h0, bus.mem_req}, 32'h1);
            chk("lw_addr",  bus.mem_addr, 32'h100);
            chk("lw_be",    {28'h0, bus.mem_be}, 32'hF);
            chk("lw_we",    {31'h0, bus.mem_we}, 32'h0);
            tick();
            chk("lw_bubble_IRW", IRW, 32'h0);
        end
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("lw_ack_stall", {31'h0, stall_m}, 32'h0);
        tick();
        chk("lw_IRW",  IRW, C_LW);
        chk("lw_DRW",  DRW, 32'hDEAD_BEEF);
        chk("lw_AOW",  AOW, 32'h100);
        chk("lw_PC4W", PC4W, 32'h108);

        // ---- sb zero-wait at byte lane 3
        IRM = C_SB; PC4M = 32'h10C; AOM = 32'h103; RTM = 32'h1234_5678;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("sb_be",    {28'h0, bus.mem_be}, 32'h8);
        chk("sb_wdata", bus.mem_wdata, 32'h7878_7878);
        chk("sb_we",    {31'h0, bus.mem_we}, 32'h1);
        chk("sb_addr",  bus.mem_addr, 32'h100);
        chk("sb_req",   {31'h0, bus.mem_req}, 32'h1);
        chk("sb_stall", {31'h0, stall_m}, 32'h0);
        tick();
        chk("sb_IRW", IRW, C_SB);
        chk("sb_DRW", DRW, 32'h0);

        // ---- sh zero-wait, upper half
        IRM = C_SH; AOM = 32'h102;
        #1;
        chk("sh_be",    {28'h0, bus.mem_be}, 32'hC);
        chk("sh_wdata", bus.mem_wdata, 32'h5678_5678);
        tick();
        chk("sh_IRW", IRW, C_SH);

        // ---- misaligned lh and sw: no request, no stall, exception codes
        IRM = C_LH; PC4M = 32'h110; AOM = 32'h101;
        #1;
        chk("lh_req",   {31'h0, bus.mem_req}, 32'h0);
        chk("lh_stall", {31'h0, stall_m}, 32'h0);
        tick();
        chk("lh_ExcW", {30'h0, ExcW}, 32'h1);
        chk("lh_IRW",  IRW, C_LH);
        chk("lh_DRW",  DRW, 32'h0);
        IRM = C_SW; AOM = 32'h102;
        #1;
        chk("sw_req", {31'h0, bus.mem_req}, 32'h0);
        tick();
        chk("sw_ExcW", {30'h0, ExcW}, 32'h2);
        chk("sw_IRW",  IRW, C_SW);

        // ---- lw never acked: 4 stall cycles, then bus timeout
        bus.mem_ack = 1'b0;
        IRM = C_LW; PC4M = 32'h200; AOM = 32'h200;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("tmo_stall", {31'h0, stall_m}, 32'h1);
            tick();
            chk("tmo_bubble_IRW", IRW, 32'h0);
        end
        #1;
        chk("tmo_last_stall", {31'h0, stall_m}, 32'h0);
        tick();
        chk("tmo_ExcW", {30'h0, ExcW}, 32'h3);
        chk("tmo_IRW",  IRW, C_LW);
        chk("tmo_DRW",  DRW, 32'h0);
        // late ack after the abort must have no effect
        IRM = 32'h0; AOM = 32'h0; PC4M = 32'h0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
        #1;
        chk("late_req", {31'h0, bus.mem_req}, 32'h0);
        tick();
        chk("late_IRW",  IRW, 32'h0);
        chk("late_DRW",  DRW, 32'h0);
        chk("late_ExcW", {30'h0, ExcW}, 32'h0);

        // ---- reset during the 2nd WAIT cycle drops the access
        bus.mem_ack = 1'b0;
        IRM = C_LW; PC4M = 32'h304; AOM = 32'h300;
        tick();   // IDLE -> WAIT
        tick();   // 1st WAIT -> 2nd WAIT
        reset = 1'b1;
        tick();
        chk("rstw_req", {31'h0, bus.mem_req}, 32'h0);
        chk("rstw_IRW", IRW, 32'h0);
        reset = 1'b0;
        // back in IDLE: a zero-wait access completes in one cycle
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1111_2222;
        #1;
        chk("rstw_stall", {31'h0, stall_m}, 32'h0);
        tick();
        chk("rstw_IRW", IRW, C_LW);
        chk("rstw_DRW", DRW, 32'h1111_2222);
        bus.mem_ack = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
